counter_sched: RTL and testbench



---
 rtl/counter_sched.sv | 163 ++++++++++++++++
 tb/tb_counter_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// -----------------------------------------------------------------------------
// counter_sched
//
// Programmable controller sequencing an up-counter. A configuration (terminal
// count, prescale divider, one-shot/periodic mode) is accepted through a
// valid/ready handshake while the controller is idle or done. The count is
// then started, paused, resumed and stopped on command. A one-cycle tick
// reports every terminal-count step. After reset the block behaves as a
// free-running wrap-around counter (limit all ones, prescale 0, periodic).
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   reset         asynchronous, active-high reset
//   cfg_valid     configuration offer
//   cfg_ready     configuration can be accepted (IDLE or DONE)
//   cfg_limit     terminal count
//   cfg_prescale  one count step every cfg_prescale+1 cycles
//   cfg_periodic  1 = reload at terminal count, 0 = one-shot
//   start         begin a run, or resume from HOLD
//   stop          pause a run, or abort from HOLD (wins over start)
//   value         current count
//   busy          high while running
//   tick          one-cycle pulse after each terminal-count step
//   done          high while in DONE (one-shot finished)
// -----------------------------------------------------------------------------
module counter_sched #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_limit,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_periodic,
  input  logic                  start,
  input  logic                  stop,
  output logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  tick,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      value_q, value_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0]      limit_q, limit_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  periodic_q, periodic_d;
  logic                  tick_q, tick_d;

  logic cfg_xfer;
  logic step;

  // Configuration is only accepted while no run is in progress.
  assign cfg_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign cfg_xfer  = cfg_valid && cfg_ready;

  // The prescale counter reaching the divider marks a count step.
  assign step = (pcnt_q == prescale_q);

  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // through the case statement leaves a signal unassigned (no latches).
    state_d    = state_q;
    value_d    = value_q;
    pcnt_d     = pcnt_q;
    limit_d    = limit_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;
    tick_d     = 1'b0;

    if (cfg_xfer) begin
      limit_d    = cfg_limit;
      prescale_d = cfg_prescale;
      periodic_d = cfg_periodic;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !stop) begin
          // Launch uses limit_d/prescale_d, so a same-edge config applies.
          state_d = S_RUN;
          value_d = '0;
          pcnt_d  = '0;
        end else if (cfg_xfer) begin
          // Accepting a config in DONE clears done; value is kept.
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (stop) begin
          // Pause: value and prescale phase freeze, no step on this edge.
          state_d = S_HOLD;
        end else if (step) begin
          pcnt_d = '0;
          if (value_q == limit_q) begin
            tick_d = 1'b1;
            if (periodic_q) begin
              value_d = '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            value_d = value_q + 1'b1;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (stop) begin
          state_d = S_IDLE;
          value_d = '0;
          pcnt_d  = '0;
        end else if (start) begin
          // Resume with the preserved phase so the cadence is unbroken.
          state_d = S_RUN;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      value_q    <= '0;
      pcnt_q     <= '0;
      limit_q    <= '1;
      prescale_q <= '0;
      periodic_q <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      pcnt_q     <= pcnt_d;
      limit_q    <= limit_d;
      prescale_q <= prescale_d;
      periodic_q <= periodic_d;
      tick_q     <= tick_d;
    end
  end

  assign value = value_q;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign tick  = tick_q;

endmodule

// File: tb/tb_counter_sched.sv
// -----------------------------------------------------------------------------
// tb_counter_sched
//
// Self-checking bench for counter_sched. A behavioural model tracks the
// controller mode, the count and a countdown to the next step; a compare
// process checks every DUT output against it on each falling edge. Directed
// sequences with literal expectations pin the model, then a long random
// phase exercises handshake, start/stop and config combinations.
// -----------------------------------------------------------------------------
module tb_counter_sched;

  logic       clk;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_limit;
  logic [3:0] cfg_prescale;
  logic       cfg_periodic;
  logic       start;
  logic       stop;
  logic [7:0] value;
  logic       busy;
  logic       tick;
  logic       done;

  int n_checks = 0;
  int n_err    = 0;

  counter_sched #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_limit    (cfg_limit),
    .cfg_prescale (cfg_prescale),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .value        (value),
    .busy         (busy),
    .tick         (tick),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: mode, count, and cycles remaining until the next step.
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE} mode_e;

  mode_e      m_mode;
  logic [7:0] m_value;
  logic [7:0] m_limit;
  int         m_wait;
  int         m_pre;
  bit         m_per;
  bit         m_tick;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode  <= M_IDLE;
      m_value <= 8'd0;
      m_wait  <= 0;
      m_limit <= 8'hFF;
      m_pre   <= 0;
      m_per   <= 1'b1;
      m_tick  <= 1'b0;
    end else begin
      m_tick <= 1'b0;
      case (m_mode)
        M_IDLE, M_DONE: begin
          if (cfg_valid) begin
            m_limit <= cfg_limit;
            m_pre   <= int'(cfg_prescale);
            m_per   <= cfg_periodic;
            if (m_mode == M_DONE) m_mode <= M_IDLE;
          end
          if (start && !stop) begin
            m_mode  <= M_RUN;
            m_value <= 8'd0;
            m_wait  <= cfg_valid ? int'(cfg_prescale) : m_pre;
          end
        end
        M_RUN: begin
          if (stop) begin
            m_mode <= M_HOLD;
          end else if (m_wait != 0) begin
            m_wait <= m_wait - 1;
          end else begin
            m_wait <= m_pre;
            if (m_value == m_limit) begin
              m_tick <= 1'b1;
              if (m_per) m_value <= 8'd0;
              else       m_mode  <= M_DONE;
            end else begin
              m_value <= m_value + 8'd1;
            end
          end
        end
        M_HOLD: begin
          if (stop) begin
            m_mode  <= M_IDLE;
            m_value <= 8'd0;
          end else if (start) begin
            m_mode <= M_RUN;
          end
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    check("model_value", 32'(value), 32'(m_value));
    check("model_busy", 32'(busy), 32'(m_mode == M_RUN));
    check("model_done", 32'(done), 32'(m_mode == M_DONE));
    check("model_tick", 32'(tick), 32'(m_tick));
    check("model_cfg_ready", 32'(cfg_ready), 32'((m_mode == M_IDLE) || (m_mode == M_DONE)));
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset        = 1'b1;
    cfg_valid    = 1'b0;
    cfg_limit    = 8'd0;
    cfg_prescale = 4'd0;
    cfg_periodic = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_value", 32'(value), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

    // Default config: free-running wrap-around counter.
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    check("free_start_busy", 32'(busy), 32'd1);
    check("free_start_value", 32'(value), 32'd0);
    check("free_cfg_ready", 32'(cfg_ready), 32'd0);
    cycles(255);
    check("free_value_ff", 32'(value), 32'hFF);
    check("free_no_tick", 32'(tick), 32'd0);
    cycles(1);
    check("free_wrap_value", 32'(value), 32'd0);
    check("free_wrap_tick", 32'(tick), 32'd1);
    check("free_wrap_busy", 32'(busy), 32'd1);
    cycles(1);
    check("free_tick_drop", 32'(tick), 32'd0);
    check("free_after_wrap", 32'(value), 32'd1);

    // Pause then abort back to IDLE.
    stop = 1'b1;
    cycles(1);
    check("pause_busy", 32'(busy), 32'd0);
    check("pause_value", 32'(value), 32'd1);
    cycles(1);
    stop = 1'b0;
    check("abort_value", 32'(value), 32'd0);
    check("abort_cfg_ready", 32'(cfg_ready), 32'd1);

    // One-shot: limit 5, step every 3 cycles.
    cfg_valid = 1'b1; cfg_limit = 8'd5; cfg_prescale = 4'd2; cfg_periodic = 1'b0;
    cycles(1);
    cfg_valid = 1'b0;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(2);
    check("os_before_step", 32'(value), 32'd0);
    cycles(1);
    check("os_first_step", 32'(value), 32'd1);
    cycles(12);
    check("os_value5", 32'(value), 32'd5);
    check("os_busy", 32'(busy), 32'd1);
    cycles(3);
    check("os_done", 32'(done), 32'd1);
    check("os_done_busy", 32'(busy), 32'd0);
    check("os_tick", 32'(tick), 32'd1);
    check("os_hold5", 32'(value), 32'd5);
    check("os_cfg_ready", 32'(cfg_ready), 32'd1);
    cycles(1);
    check("os_tick_once", 32'(tick), 32'd0);
    check("os_still_done", 32'(done), 32'd1);

    // Config in DONE returns to IDLE keeping the value.
    cfg_valid = 1'b1; cfg_limit = 8'd3; cfg_prescale = 4'd0; cfg_periodic = 1'b1;
    cycles(1);
    cfg_valid = 1'b0;
    check("done_cfg_clear", 32'(done), 32'd0);
    check("done_cfg_value", 32'(value), 32'd5);

    // Periodic limit 3 with pause at value 2.
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(2);
    check("per_value2", 32'(value), 32'd2);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    check("per_hold_busy", 32'(busy), 32'd0);
    cycles(7);
    check("per_hold_value", 32'(value), 32'd2);
    check("per_hold_ready", 32'(cfg_ready), 32'd0);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    check("per_resume_value", 32'(value), 32'd2);
    cycles(1);
    check("per_resume_step", 32'(value), 32'd3);
    cycles(1);
    check("per_wrap_value", 32'(value), 32'd0);
    check("per_wrap_tick", 32'(tick), 32'd1);

    // start && stop in RUN pauses; cfg ignored in HOLD; stop aborts.
    start = 1'b1; stop = 1'b1;
    cycles(1);
    start = 1'b0; stop = 1'b0;
    check("ss_hold_busy", 32'(busy), 32'd0);
    cfg_valid = 1'b1; cfg_limit = 8'd0; cfg_prescale = 4'd1; cfg_periodic = 1'b1;
    #1 check("hold_cfg_ready", 32'(cfg_ready), 32'd0);
    cycles(1);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    check("hold_abort_value", 32'(value), 32'd0);
    check("hold_abort_ready", 32'(cfg_ready), 32'd1);
    cycles(1);
    cfg_valid = 1'b0;

    // limit 0, prescale 1: tick every 2 cycles, value stays 0.
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(1);
    check("l0_no_tick", 32'(tick), 32'd0);
    cycles(1);
    check("l0_tick1", 32'(tick), 32'd1);
    check("l0_value", 32'(value), 32'd0);
    cycles(1);
    check("l0_gap", 32'(tick), 32'd0);
    cycles(1);
    check("l0_tick2", 32'(tick), 32'd1);

    // Mid-cycle asynchronous reset at value 0x40.
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(64);
    check("pre_reset_value", 32'(value), 32'h40);
    #2 reset = 1'b1;
    #1;
    check("arst_value", 32'(value), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    check("post_rst_busy", 32'(busy), 32'd1);
    cycles(1);
    check("post_rst_value1", 32'(value), 32'd1);
    cycles(254);
    check("post_rst_valueff", 32'(value), 32'hFF);

    // Random phase against the model.
    for (int i = 0; i < 3000; i++) begin
      cfg_valid    = ($urandom_range(0, 3) == 0);
      cfg_limit    = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      cfg_prescale = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      cfg_periodic = 1'($urandom_range(0, 1));
      start        = ($urandom_range(0, 4) == 0);
      stop         = ($urandom_range(0, 11) == 0);
      cycles(1);
    end

    cfg_valid = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    cycles(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
